// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel column feeder and its line memories.
package sobel_pkg;

  localparam int PIX_W          = 8;
  localparam int DATA_W         = 9;
  localparam int DEF_IMG_WIDTH  = 640;
  localparam int DEF_IMG_HEIGHT = 480;

  typedef logic [PIX_W-1:0]         pixel_t;
  typedef logic signed [DATA_W-1:0] sdata_t;

  // Unsigned grey pixel to the MAC input format: positive signed, zero-extended.
  function automatic sdata_t to_sdata(input pixel_t p);
    return sdata_t'({1'b0, p});
  endfunction

endpackage

// File: rtl/sobel_column_feeder_if.sv
// Pixel-in / column-out bus of the column feeder.
// Handshake: InPixelDe qualifies InPixel for exactly the cycle it is high; there is
// no ready, the feeder accepts every cycle. OutDataDe qualifies OutData1..3,
// OutCol and OutRow for that cycle; consumers have no backpressure and must take
// every cycle OutDataDe is high. OutFrameEnd pulses with the last column of a frame.
interface sobel_column_feeder_if #(
  parameter int COL_W = 10,
  parameter int ROW_W = 9
);
  import sobel_pkg::*;

  pixel_t             InPixel;
  logic               InPixelDe;
  sdata_t             OutData1;
  sdata_t             OutData2;
  sdata_t             OutData3;
  logic               OutDataDe;
  logic [COL_W-1:0]   OutCol;
  logic [ROW_W-1:0]   OutRow;
  logic               OutFrameEnd;

  // Feeder side: consumes pixels, drives columns.
  modport master (
    input  InPixel, InPixelDe,
    output OutData1, OutData2, OutData3, OutDataDe, OutCol, OutRow, OutFrameEnd
  );

  // Environment side: drives pixels, consumes columns.
  modport slave (
    output InPixel, InPixelDe,
    input  OutData1, OutData2, OutData3, OutDataDe, OutCol, OutRow, OutFrameEnd
  );

endinterface

// File: rtl/sobel_line_ram.sv
// One line of pixels. Combinational read of the old contents at addr_i, write at
// the clock edge, so a same-address read/write returns the pre-write value and
// adds no latency to the feeder's output register.
module sobel_line_ram
  import sobel_pkg::*;
#(
  parameter int DEPTH  = DEF_IMG_WIDTH,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  pixel_t            wdata_i,
  output pixel_t            rdata_o
);

  pixel_t mem_q [DEPTH];

  // Read port: old value at the shared address.
  assign rdata_o = mem_q[addr_i];

  // Write port: new value lands at the clock edge, after the read above.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/sobel_column_feeder.sv
// Turns a raster grey pixel stream into vertical 3-pixel columns (rows y-2, y-1, y)
// for the Sobel MAC cores. Two line memories hold the previous two rows; the first
// two rows of each frame only fill them. Output is registered, one cycle after
// the accepted pixel.
module sobel_column_feeder
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 9
) (
  input  logic                  InClk,
  input  logic                  InRst,
  sobel_column_feeder_if.master bus
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST_OUT = ROW_W'(2);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  sdata_t           d1_q, d1_d;
  sdata_t           d2_q, d2_d;
  sdata_t           d3_q, d3_d;
  logic [COL_W-1:0] out_col_q, out_col_d;
  logic [ROW_W-1:0] out_row_q, out_row_d;
  logic             de_q, de_d;
  logic             fe_q, fe_d;

  pixel_t lb0_rd;   // row y-1 at this column
  pixel_t lb1_rd;   // row y-2 at this column
  logic   wr_en;
  logic   emit;
  logic   col_wrap;

  // A pixel sampled together with reset is discarded: nothing is stored.
  assign wr_en    = bus.InPixelDe && !InRst;
  assign emit     = bus.InPixelDe && (row_q >= ROW_FIRST_OUT);
  assign col_wrap = (col_q == COL_LAST);

  // LB0 shifts in the new pixel; LB1 takes the row that LB0 is giving up.
  sobel_line_ram #(.DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_lb0 (
    .clk_i   (InClk),
    .we_i    (wr_en),
    .addr_i  (col_q),
    .wdata_i (bus.InPixel),
    .rdata_o (lb0_rd)
  );

  sobel_line_ram #(.DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_lb1 (
    .clk_i   (InClk),
    .we_i    (wr_en),
    .addr_i  (col_q),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  // Next-state: raster position, output column register and flags.
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    d1_d      = d1_q;
    d2_d      = d2_q;
    d3_d      = d3_q;
    out_col_d = out_col_q;
    out_row_d = out_row_q;
    de_d      = emit;
    fe_d      = bus.InPixelDe && (row_q == ROW_LAST) && col_wrap;

    if (bus.InPixelDe) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    // Data registers hold between valid outputs.
    if (emit) begin
      d1_d      = to_sdata(lb1_rd);
      d2_d      = to_sdata(lb0_rd);
      d3_d      = to_sdata(bus.InPixel);
      out_col_d = col_q;
      out_row_d = row_q;
    end
  end

  // State registers; reset returns to position (0,0) with cleared outputs.
  always_ff @(posedge InClk) begin
    if (InRst) begin
      col_q     <= '0;
      row_q     <= '0;
      d1_q      <= '0;
      d2_q      <= '0;
      d3_q      <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
      de_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      d3_q      <= d3_d;
      out_col_q <= out_col_d;
      out_row_q <= out_row_d;
      de_q      <= de_d;
      fe_q      <= fe_d;
    end
  end

  assign bus.OutData1    = d1_q;
  assign bus.OutData2    = d2_q;
  assign bus.OutData3    = d3_q;
  assign bus.OutDataDe   = de_q;
  assign bus.OutCol      = out_col_q;
  assign bus.OutRow      = out_row_q;
  assign bus.OutFrameEnd = fe_q;

endmodule

// File: tb/tb_sobel_column_feeder.sv
// Bench for sobel_column_feeder on a 4x4 image: directed frames plus random
// gaps/resets, compared every cycle against an image-array model.
module tb_sobel_column_feeder;

  localparam int W     = 4;
  localparam int H     = 4;
  localparam int COL_W = 2;
  localparam int ROW_W = 2;

  typedef struct {
    logic [8:0] d1;
    logic [8:0] d2;
    logic [8:0] d3;
    int         col;
    int         row;
    bit         fe;
  } out_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic in_rst;
  logic in_de;
  logic [7:0] in_pix;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sobel_column_feeder_if #(.COL_W(COL_W), .ROW_W(ROW_W)) bus ();

  assign bus.InPixel   = in_pix;
  assign bus.InPixelDe = in_de;

  sobel_column_feeder #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .COL_W     (COL_W),
    .ROW_W     (ROW_W)
  ) dut (
    .InClk (clk),
    .InRst (in_rst),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 0;
  bit log_en   = 0;
  out_t act_q[$];
  out_t mdl_q[$];
  out_t q1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [63:0] key(input out_t t);
    return {13'd0, t.d1, t.d2, t.d3, t.col[7:0], t.row[7:0], 7'd0, t.fe};
  endfunction

  // ---------------- behavioural model ----------------
  // Image array indexed by raster position; an output is the column of the
  // current pixel and the two rows above it in the same frame.
  logic [7:0] img [H][W];
  int         mrow = 0, mcol = 0;
  logic [8:0] e1, e2, e3;
  int         ecol, erow;
  bit         ede = 0, efe = 0;

  always @(posedge clk) begin
    if (in_rst) begin
      mrow = 0; mcol = 0;
      e1 = 0; e2 = 0; e3 = 0; ecol = 0; erow = 0; ede = 0; efe = 0;
    end else begin
      ede = in_de && (mrow >= 2);
      efe = in_de && (mrow == H - 1) && (mcol == W - 1);
      if (in_de) begin
        img[mrow][mcol] = in_pix;
        if (mrow >= 2) begin
          e1 = {1'b0, img[mrow-2][mcol]};
          e2 = {1'b0, img[mrow-1][mcol]};
          e3 = {1'b0, in_pix};
          ecol = mcol;
          erow = mrow;
          if (log_en) mdl_q.push_back('{e1, e2, e3, ecol, erow, efe});
        end
        mcol++;
        if (mcol == W) begin
          mcol = 0;
          mrow = (mrow == H - 1) ? 0 : mrow + 1;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("de",   64'(bus.OutDataDe),   64'(ede));
      chk("fe",   64'(bus.OutFrameEnd), 64'(efe));
      chk("d1",   64'($unsigned(bus.OutData1)), 64'(e1));
      chk("d2",   64'($unsigned(bus.OutData2)), 64'(e2));
      chk("d3",   64'($unsigned(bus.OutData3)), 64'(e3));
      chk("col",  64'(bus.OutCol), 64'(ecol));
      chk("row",  64'(bus.OutRow), 64'(erow));
      if (bus.OutDataDe) begin
        chk("nonneg", 64'(bus.OutData1[8] | bus.OutData2[8] | bus.OutData3[8]), 64'd0);
        if (log_en)
          act_q.push_back('{$unsigned(bus.OutData1), $unsigned(bus.OutData2),
                            $unsigned(bus.OutData3), int'(bus.OutCol),
                            int'(bus.OutRow), bus.OutFrameEnd});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic r, input logic d, input logic [7:0] p);
    in_rst = r; in_de = d; in_pix = p;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 8'h00);
  endtask

  // kind 0: base+row*16+col, kind 1: 0xFF everywhere
  task automatic feed(input int kind, input int base, input int r0, input int r1, input bit gaps);
    for (int r = r0; r <= r1; r++) begin
      for (int c = 0; c < W; c++) begin
        logic [7:0] p;
        p = (kind == 0) ? 8'(base + r * 16 + c) : 8'hFF;
        cycle(1'b0, 1'b1, p);
        if (gaps) begin
          idle(1);
          if (r == 2 && c == 1) idle(5);
        end
      end
    end
  endtask

  task automatic clear_logs();
    act_q.delete();
    mdl_q.delete();
  endtask

  task automatic cmp_with_q1(input string name);
    chk({name, "_count"}, 64'(act_q.size()), 64'(q1.size()));
    for (int i = 0; i < act_q.size() && i < q1.size(); i++)
      chk(name, key(act_q[i]), key(q1[i]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_ff;
    out_t lit;
    in_rst = 1'b1; in_de = 1'b0; in_pix = 8'h00;
    @(posedge clk);
    #1;
    check_en = 1;
    cycle(1'b1, 1'b0, 8'h00);

    // reset state
    chk("rst_de", 64'(bus.OutDataDe), 64'd0);
    chk("rst_fe", 64'(bus.OutFrameEnd), 64'd0);
    chk("rst_d1", 64'($unsigned(bus.OutData1)), 64'd0);
    chk("rst_d3", 64'($unsigned(bus.OutData3)), 64'd0);

    // 1: continuous frame
    log_en = 1;
    clear_logs();
    feed(0, 0, 0, 3, 0);
    idle(2);
    q1 = act_q;
    chk("s1_count", 64'(act_q.size()), 64'd8);
    chk("s1_model_count", 64'(mdl_q.size()), 64'd8);
    lit = '{9'd0, 9'd16, 9'd32, 0, 2, 1'b0};
    if (act_q.size() > 0) chk("s1_first", key(act_q[0]), key(lit));
    if (mdl_q.size() > 0) chk("s1_model_first", key(mdl_q[0]), key(lit));
    lit = '{9'h13, 9'h23, 9'h33, 3, 3, 1'b1};
    if (act_q.size() == 8) chk("s1_last", key(act_q[7]), key(lit));
    if (mdl_q.size() == 8) chk("s1_model_last", key(mdl_q[7]), key(lit));

    // 2: de toggling plus a 5-cycle gap mid row 2
    clear_logs();
    feed(0, 0, 0, 3, 1);
    idle(2);
    cmp_with_q1("s2_seq");

    // 3: back-to-back frames
    clear_logs();
    feed(0, 0, 0, 3, 0);
    feed(0, 8'h80, 0, 3, 0);
    idle(2);
    chk("s3_count", 64'(act_q.size()), 64'd16);
    lit = '{9'h80, 9'h90, 9'hA0, 0, 2, 1'b0};
    if (act_q.size() > 8) chk("s3_f2_first", key(act_q[8]), key(lit));
    for (int i = 8; i < act_q.size(); i++)
      chk("s3_no_leak", 64'(act_q[i].d1 >= 9'h80), 64'd1);

    // 4: reset at pixel (2,1)
    feed(0, 0, 0, 1, 0);
    cycle(1'b0, 1'b1, 8'h20);
    cycle(1'b1, 1'b1, 8'h21);
    chk("s4_de",  64'(bus.OutDataDe), 64'd0);
    chk("s4_d1",  64'($unsigned(bus.OutData1)), 64'd0);
    chk("s4_d2",  64'($unsigned(bus.OutData2)), 64'd0);
    chk("s4_d3",  64'($unsigned(bus.OutData3)), 64'd0);
    clear_logs();
    feed(0, 0, 0, 1, 0);
    chk("s4_fill_silent", 64'(act_q.size()), 64'd0);
    feed(0, 0, 2, 3, 0);
    idle(2);
    cmp_with_q1("s4_seq");

    // 5: reset together with a 0xFF pixel
    cycle(1'b1, 1'b1, 8'hFF);
    clear_logs();
    feed(0, 0, 0, 3, 0);
    idle(2);
    cmp_with_q1("s5_seq");
    n_ff = 0;
    foreach (act_q[i])
      if (act_q[i].d1 == 9'h0FF || act_q[i].d2 == 9'h0FF || act_q[i].d3 == 9'h0FF) n_ff++;
    chk("s5_no_ff", 64'(n_ff), 64'd0);

    // 6: all 0xFF
    clear_logs();
    feed(1, 0, 0, 3, 0);
    idle(2);
    chk("s6_count", 64'(act_q.size()), 64'd8);
    foreach (act_q[i]) begin
      chk("s6_d1", 64'(act_q[i].d1), 64'h0FF);
      chk("s6_d2", 64'(act_q[i].d2), 64'h0FF);
      chk("s6_d3", 64'(act_q[i].d3), 64'h0FF);
    end

    // random gaps, pixels and rare resets
    log_en = 0;
    for (int i = 0; i < 1200; i++) begin
      logic r, d;
      r = ($urandom_range(0, 249) == 0);
      d = ($urandom_range(0, 9) < 7);
      cycle(r, d, 8'($urandom_range(0, 255)));
    end
    idle(2);

    check_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sobel_column_feeder.md
Name: sobel_column_feeder

Overview:
- Producer for the 3-tap Sobel MAC core's input interface: turns a raster 8-bit grey pixel stream into vertical 3-pixel columns (rows y-2, y-1, y at column x).
- Output format is signed 9-bit, zero-extended, with a data-enable.
- Sits between the video input and the MAC cores.
- Holds two line memories and tracks row/column position; the first two rows of each frame produce no output.

Parameters:
- IMG_WIDTH, 640, active pixels per line (>=3).
- IMG_HEIGHT, 480, active lines per frame (>=3).
- COL_W, 10, column counter width (>= clog2(IMG_WIDTH)).
- ROW_W, 9, row counter width (>= clog2(IMG_HEIGHT)).

Ports:
- InClk  input  1  system clock; all logic on rising edge.
- InRst  input  1  synchronous, active-high reset.
- InPixel  input  8  unsigned grey pixel.
- InPixelDe  input  1  InPixel valid this cycle; may deassert anywhere (gaps allowed).
- OutData1  output  9  signed, {1'b0, pixel row y-2, col x}.
- OutData2  output  9  signed, {1'b0, pixel row y-1, col x}.
- OutData3  output  9  signed, {1'b0, pixel row y, col x}.
- OutDataDe  output  1  OutData1..3 valid.
- OutCol  output  COL_W  column x of current output.
- OutRow  output  ROW_W  row y of current output (2..IMG_HEIGHT-1).
- OutFrameEnd  output  1  one-cycle pulse with the last output column of the frame.

Behaviour:
- Reset (InRst=1 sampled at an InClk edge): col=0, row=0, all outputs 0, OutDataDe=0, OutFrameEnd=0. Line memory contents are not cleared and are never exposed before being rewritten.
- Position counters advance only on InPixelDe=1:
  - col increments; at col=IMG_WIDTH-1 it wraps to 0 and row increments.
  - At row=IMG_HEIGHT-1 with col=IMG_WIDTH-1, row wraps to 0.
- Line memories LB0 (row y-1) and LB1 (row y-2), each depth IMG_WIDTH x 8, addressed by col. On each InPixelDe cycle, all at the same address col:
  - read LB0[col] and LB1[col];
  - write LB1[col] <= LB0[col] (old value);
  - write LB0[col] <= InPixel.
- Read-before-write at the same address is mandatory.
- Output is registered, latency exactly 1 cycle from the InPixelDe sample:
  - OutData3 = {0, InPixel}, OutData2 = {0, LB0 old}, OutData1 = {0, LB1 old}.
  - OutCol and OutRow carry the pre-increment col/row.
- OutDataDe = registered (InPixelDe && row>=2). Rows 0 and 1 only fill the memories.
- When OutDataDe=0, OutData1..3 hold their previous value; consumers must gate on OutDataDe.
- OutFrameEnd = registered (InPixelDe && row=IMG_HEIGHT-1 && col=IMG_WIDTH-1). It coincides with the final OutDataDe of the frame.
- Gaps: when InPixelDe=0, counters and memories hold and OutDataDe=0 next cycle. Gap length and position are unconstrained, including mid-line and across line/frame boundaries.
- Frame wrap: the new frame restarts at row 0, so its rows 0–1 emit nothing. Stale memory data from the prior frame is overwritten before it could be emitted.
- Reset mid-frame: counters return to 0 and the next accepted pixel is treated as (0,0). No OutDataDe until two full lines are accepted. The output register clears in the same cycle.
- InRst has priority over InPixelDe in the same cycle: the pixel is discarded and nothing is written.
- No backpressure: downstream MAC cores accept every cycle.

Decomposition:
- Shared package sobel_pkg:
  - PIX_W=8, DATA_W=9;
  - default IMG_WIDTH/IMG_HEIGHT;
  - typedef pixel_t (8-bit unsigned), sdata_t (9-bit signed).
- One sub-module, sobel_line_ram: single-clock, depth IMG_WIDTH, 8-bit, read-old-on-write, one address port with write enable, registered read optional but latency must be absorbed so top-level latency stays exactly 1.
- The top holds the counters, output register and flag logic.

Test Plan:
1. IMG_WIDTH=4, IMG_HEIGHT=4, continuous InPixelDe, pixel=row*16+col → first OutDataDe on the cycle after pixel (2,0) with Out1=0, Out2=16, Out3=32. Exactly 8 valid outputs total; the last one is (Out1=0x13, Out2=0x23, Out3=0x33), col=3, row=3, with OutFrameEnd=1.
2. Same frame with InPixelDe toggled 1/0 every cycle plus a 5-cycle gap mid-row 2 → identical output value sequence to scenario 1; OutDataDe is never high during the cycle after a gap cycle.
3. Two back-to-back frames, second frame pixel=0x80+row*16+col → frame 2 emits nothing for its rows 0–1. Its first valid output is (0x80, 0x90, 0xA0), with no frame-1 data leaking.
4. Assert InRst for 1 cycle at pixel (2,1) of frame 1 → OutDataDe=0 and all outputs 0 the next cycle. The next 8 pixels produce no output. A full restarted frame then reproduces scenario 1.
5. InRst=1 together with InPixelDe=1, InPixel=0xFF → pixel not stored, counters stay 0, and no 0xFF ever appears at the output.
6. Pixel 0xFF in all rows → outputs equal +255 (9'h0FF, positive signed), never negative.
